// File: rtl/i2c_bus_monitor.sv
// I2C bus monitor: resolves open-drain agents onto SCL/SDA, glitch-filters the
// resolved lines, decodes START/RSTART/STOP and data bytes, and queues the
// decoded events in a first-word-fall-through FIFO.
//
// state  | meaning
// IDLE   | no transfer in progress; SCL edges are ignored
// ACTIVE | between START and STOP; SCL rising edges sample data/ACK bits
module i2c_bus_monitor #(
  parameter int N_AGENTS   = 2,
  parameter int FILTER_LEN = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_AGENTS-1:0] scl_o,
  input  logic [N_AGENTS-1:0] scl_t,
  input  logic [N_AGENTS-1:0] sda_o,
  input  logic [N_AGENTS-1:0] sda_t,
  output logic                scl_i,
  output logic                sda_i,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [1:0]          evt_type,
  output logic [7:0]          evt_data,
  output logic                evt_ack,
  output logic                busy,
  output logic                overflow
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [3:0] FILT_TC = 4'(FILTER_LEN - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state, state_nxt;
  logic        scl_r, sda_r, scl_f, sda_f, scl_fd, sda_fd;
  logic [3:0]  scl_cnt, sda_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  data_sr;
  logic        scl_hold_hi, scl_rise, sda_fall, sda_rise, sda_same;
  logic        start_det, rstart_det, stop_det, bit_det, byte_done;
  logic        push;
  logic [10:0] push_word;
  logic [10:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, wr_en;

  // Wired-AND of the open-drain agents; a released agent contributes a 1.
  assign scl_i = &(scl_t | scl_o);
  assign sda_i = &(sda_t | sda_o);

  // Register the resolved lines, then accept a new level only after FILTER_LEN
  // consecutive registered samples disagree with the current filtered level.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_r   <= 1'b1;
      sda_r   <= 1'b1;
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_fd  <= 1'b1;
      sda_fd  <= 1'b1;
      scl_cnt <= 4'd0;
      sda_cnt <= 4'd0;
    end else begin
      scl_r  <= scl_i;
      sda_r  <= sda_i;
      scl_fd <= scl_f;
      sda_fd <= sda_f;
      if (scl_r == scl_f) begin
        scl_cnt <= 4'd0;
      end else if (scl_cnt == FILT_TC) begin
        scl_f   <= scl_r;
        scl_cnt <= 4'd0;
      end else begin
        scl_cnt <= scl_cnt + 4'd1;
      end
      if (sda_r == sda_f) begin
        sda_cnt <= 4'd0;
      end else if (sda_cnt == FILT_TC) begin
        sda_f   <= sda_r;
        sda_cnt <= 4'd0;
      end else begin
        sda_cnt <= sda_cnt + 4'd1;
      end
    end
  end

  // Edge decode on the filtered lines; a cycle where both lines move is ignored.
  assign scl_hold_hi = scl_fd & scl_f;
  assign scl_rise    = ~scl_fd & scl_f;
  assign sda_fall    = sda_fd & ~sda_f;
  assign sda_rise    = ~sda_fd & sda_f;
  assign sda_same    = (sda_fd == sda_f);
  assign start_det   = scl_hold_hi & sda_fall & (state == IDLE);
  assign rstart_det  = scl_hold_hi & sda_fall & (state == ACTIVE);
  assign stop_det    = scl_hold_hi & sda_rise;
  assign bit_det     = scl_rise & sda_same & (state == ACTIVE);
  assign byte_done   = bit_det & (bit_cnt == 4'd8);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: START opens a transfer, STOP closes it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_det) state_nxt = ACTIVE;
      ACTIVE:  if (stop_det)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    busy = (state == ACTIVE);
  end

  // Bit counter and data shift register; any condition abandons a partial byte.
  always_ff @(posedge clk) begin
    if (rst || start_det || rstart_det || stop_det) begin
      bit_cnt <= 4'd0;
      data_sr <= 8'h00;
    end else if (bit_det) begin
      if (bit_cnt == 4'd8) begin
        bit_cnt <= 4'd0;
      end else begin
        data_sr <= {data_sr[6:0], sda_f};
        bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end

  // Event word {type, data, ack}; conditions and byte completion never coincide.
  always_comb begin
    push      = 1'b0;
    push_word = 11'd0;
    if (start_det) begin
      push      = 1'b1;
      push_word = {2'b00, 8'h00, 1'b0};
    end else if (rstart_det) begin
      push      = 1'b1;
      push_word = {2'b01, 8'h00, 1'b0};
    end else if (stop_det) begin
      push      = 1'b1;
      push_word = {2'b10, 8'h00, 1'b0};
    end else if (byte_done) begin
      push      = 1'b1;
      push_word = {2'b11, data_sr, ~sda_f};
    end
  end

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign evt_valid = ~empty;
  assign pop       = evt_valid & evt_ready;
  assign wr_en     = push & (~full | pop);
  assign {evt_type, evt_data, evt_ack} = mem[rd_ptr[AW-1:0]];

  // FIFO storage; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_word;
  end

  // FIFO pointers and sticky overflow when a push meets a full FIFO with no pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop)   rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

endmodule
